// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CHECK,
        RELEASE
    } loader_state_e;

    localparam int ADDR_STEP      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses on the
// handshake of the final byte of a word.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_fire,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    // Each accepted byte lands in the lane selected by the byte counter.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_fire) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_data;
            cnt_d                        = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word       = word_q;
    assign word_valid = byte_fire && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a byte stream into instruction memory at byte addresses 0,4,8,... and then
// releases the core PC. Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [DATA_W-1:0] wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              resetpc_q, resetpc_d;
    logic              start_accept;
    logic              byte_fire;
    logic              word_valid;
    logic [31:0]       word;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign start_accept = start && (state_q == IDLE);
    assign s_ready      = (state_q == COLLECT) || (state_q == CHECK);
    assign byte_fire    = s_valid && s_ready;
    assign last_word    = (cnt_q == len_q - LEN_W'(1));

    imem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_accept),
        .byte_fire  (byte_fire),
        .byte_data  (s_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        resetpc_d = resetpc_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len_words;
                    cnt_d     = '0;
                    addr_d    = '0;
                    resetpc_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    err_d     = 1'b0;
`endif
                    state_d   = (len_words == '0) ? RELEASE : COLLECT;
                end
            end
            COLLECT: begin
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(ADDR_STEP);
                cnt_d  = cnt_q + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d  = sum_q + word;
                state_d = last_word ? CHECK : COLLECT;
`else
                state_d = last_word ? RELEASE : COLLECT;
`endif
            end
            CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (word_valid) state_d = RELEASE;
`else
                state_d = IDLE;
`endif
            end
            RELEASE: begin
                resetpc_d = 1'b1;
                state_d   = IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                // The packer now holds the trailer word; zero-length loads carry no trailer.
                if ((len_q != '0) && (word != sum_q)) err_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            resetpc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            resetpc_q <= resetpc_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign we0      = (state_q == WRITE);
    assign wr_addr0 = addr_q;
    assign wr_din0  = word;
    assign resetpc  = resetpc_q;
    assign busy     = (state_q == COLLECT) || (state_q == WRITE) || (state_q == CHECK);
    assign done     = (state_q == RELEASE);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: table-driven loads, random loads and
// hand-written corner sequences, checked against a word-list reference model.
module tb_imem_stream_loader;

    localparam int ADDR_W = 9;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len_words = '0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [31:0]       wr_din0;
    logic              resetpc;
    logic              busy;
    logic              done;
    logic              err;

    imem_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(32), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len_words (len_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .we0       (we0),
        .wr_addr0  (wr_addr0),
        .wr_din0   (wr_din0),
        .resetpc   (resetpc),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the words to load; the expected image is words[i] at (i*4) mod 2^ADDR_W.
    logic [31:0] words [0:255];

    int          capAddr[$];
    logic [31:0] capData[$];
    int          doneCount = 0;
    logic        busyAtDone = 1'b0;
    bit          sReadySeen = 1'b0;
    bit          toggleBit = 1'b0;

    typedef struct {
        int          len;
        int          stall;
        logic [31:0] w0;
        logic [31:0] w1;
        int          trailerAdj;
        logic        expErr;
    } loadVec_t;

    loadVec_t vecs[$];

    function automatic void checkVal(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Output monitor samples one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (we0 === 1'b1) begin
            capAddr.push_back(int'(wr_addr0));
            capData.push_back(wr_din0);
        end
        if (done === 1'b1) begin
            doneCount++;
            busyAtDone = busy;
        end
        if (s_ready === 1'b1) sReadySeen = 1'b1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearMonitor();
        capAddr.delete();
        capData.delete();
        doneCount  = 0;
        sReadySeen = 1'b0;
    endtask

    // Offers one byte, possibly stalling, until it is accepted; entered and left at a negedge.
    task automatic applyStimulus(input logic [7:0] b, input int stall, output bit ok);
        int  guard;
        bit  taken;
        guard = 0;
        ok    = 1'b0;
        while (!ok && guard < 50) begin
            toggleBit = ~toggleBit;
            if ((stall == 1 && toggleBit) || (stall == 2 && $urandom_range(1) == 0)) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = b;
            end
            taken = s_valid && (s_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
            ok = taken;
            guard++;
        end
        if (!ok) checkVal("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkOutput(input int len, input logic expErr);
        int guard;
        guard = 0;
        while (doneCount == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkVal("done_seen", doneCount, 1);
        checkVal("busy_at_done", busyAtDone, 0);
        checkVal("write_count", capAddr.size(), len);
        for (int i = 0; i < capAddr.size() && i < len; i++) begin
            checkVal("cap_addr", capAddr[i], (i * 4) % (1 << ADDR_W));
            checkVal("cap_data", capData[i], words[i]);
        end
        @(negedge clk);
        checkVal("resetpc_after_done", resetpc, 1);
        checkVal("busy_after_done", busy, 0);
        checkVal("err_after_done", err, expErr);
        checkVal("done_single_pulse", doneCount, 1);
    endtask

    task automatic runLoad(input int len, input int stall, input int trailerAdj, input logic expErr);
        bit          ok;
        logic [31:0] sum;
        logic [31:0] trailer;
        logic [31:0] w;
        sum = '0;
        for (int i = 0; i < len; i++) sum = sum + words[i];
        trailer = sum + 32'(trailerAdj);
        clearMonitor();
        start     = 1'b1;
        len_words = LEN_W'(len);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int wi = 0; wi < len; wi++) begin
            w = words[wi];
            for (int k = 0; k < 4; k++) begin
                applyStimulus(w[8*k +: 8], stall, ok);
            end
            checkVal("we0_latency", we0, 1);
            checkVal("wr_addr0_live", wr_addr0, (wi * 4) % (1 << ADDR_W));
            checkVal("wr_din0_live", wr_din0, w);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (len > 0) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(trailer[8*k +: 8], stall, ok);
            end
            checkVal("trailer_no_we0", we0, 0);
        end
`endif
        s_valid = 1'b0;
        checkOutput(len, expErr);
    endtask

    initial begin
        bit ok;
        logic [31:0] w;

        // Reset values while reset is held low.
        #2;
        checkVal("rst_s_ready", s_ready, 0);
        checkVal("rst_we0", we0, 0);
        checkVal("rst_wr_addr0", wr_addr0, 0);
        checkVal("rst_wr_din0", wr_din0, 0);
        checkVal("rst_resetpc", resetpc, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle after reset with no start.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkVal("idle_resetpc", resetpc, 0);
            checkVal("idle_we0", we0, 0);
            checkVal("idle_s_ready", s_ready, 0);
        end

        // Table-driven loads.
        vecs.push_back('{len: 2, stall: 0, w0: 32'h0000_0013, w1: 32'h0010_0093, trailerAdj: 0, expErr: 1'b0});
        vecs.push_back('{len: 3, stall: 1, w0: 32'hDEAD_BEEF, w1: 32'h0123_4567, trailerAdj: 0, expErr: 1'b0});
        vecs.push_back('{len: 1, stall: 2, w0: 32'hA5A5_5A5A, w1: 32'h0, trailerAdj: 0, expErr: 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{len: 2, stall: 0, w0: 32'h1, w1: 32'h2, trailerAdj: 0, expErr: 1'b0});
        vecs.push_back('{len: 2, stall: 0, w0: 32'h1, w1: 32'h2, trailerAdj: 1, expErr: 1'b1});
`endif
        foreach (vecs[v]) begin
            for (int i = 0; i < 256; i++) words[i] = $urandom;
            words[0] = vecs[v].w0;
            words[1] = vecs[v].w1;
            runLoad(vecs[v].len, vecs[v].stall, vecs[v].trailerAdj, vecs[v].expErr);
        end

        // Zero-length load: done the cycle after start, no writes, never ready.
        clearMonitor();
        start     = 1'b1;
        len_words = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkVal("len0_done_next", doneCount, 1);
        checkVal("len0_busy_at_done", busyAtDone, 0);
        checkVal("len0_resetpc_low", resetpc, 0);
        @(negedge clk);
        checkVal("len0_resetpc_high", resetpc, 1);
        repeat (3) @(negedge clk);
        checkVal("len0_no_write", capAddr.size(), 0);
        checkVal("len0_never_ready", sReadySeen, 0);
        checkVal("len0_err", err, 0);

        // Randomized loads.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) words[i] = $urandom;
            runLoad($urandom_range(8, 1), $urandom_range(2), 0, 1'b0);
        end

        // Asynchronous reset after two bytes of word 1.
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        clearMonitor();
        start     = 1'b1;
        len_words = LEN_W'(2);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            w = words[k / 4];
            applyStimulus(w[8*(k%4) +: 8], 0, ok);
        end
        reset = 1'b0;
        #1;
        checkVal("midrst_s_ready", s_ready, 0);
        checkVal("midrst_we0", we0, 0);
        checkVal("midrst_wr_addr0", wr_addr0, 0);
        checkVal("midrst_wr_din0", wr_din0, 0);
        checkVal("midrst_resetpc", resetpc, 0);
        checkVal("midrst_busy", busy, 0);
        checkVal("midrst_done", done, 0);
        checkVal("midrst_err", err, 0);
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        words[0] = $urandom;
        runLoad(1, 0, 0, 1'b0);

        // Address wrap: 130 words with a 9-bit byte address.
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        runLoad(130, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
